// File: rtl/des_cpu_if.sv
// des_cpu_if: memory-mapped bridge between the CPU data bus and the DES core wrapper.
// Bit 1 of every DES word/block is the MSB, so "wdata bit 32" is wdata[0].
module des_cpu_if #(
    parameter int LATENCY  = 16,
    parameter bit KEY_KEEP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [2:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        busy,
    output logic        done,
    output logic [63:0] des_plaintext,
    output logic [63:0] des_key,
    input  logic [63:0] des_result
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t      state;
    logic [63:0] pt, key, result;
    logic [3:0]  mask;
    logic        err;
    logic [7:0]  cnt;
    logic [31:0] rd_word;
    logic        ctrl, clear, start, data_wr;

    assign ctrl          = wr_en && addr == 3'd4;
    assign clear         = ctrl && wdata[1];
    assign start         = ctrl && wdata[0] && !wdata[1];
    assign data_wr       = wr_en && !addr[2];
    assign des_plaintext = pt;
    assign des_key       = key;
    assign rd_word = addr == 3'd5 ? {24'd0, mask, 1'b0, err, done, busy} :
                     addr == 3'd6 ? result[63:32] :
                     addr == 3'd7 ? result[31:0] : 32'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pt          <= '0;
            key         <= '0;
            result      <= '0;
            mask        <= '0;
            err         <= 1'b0;
            cnt         <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            rdata_valid <= rd_en;
            if (rd_en)
                rdata <= rd_word;
            if (clear) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b0;
                mask  <= '0;
                err   <= 1'b0;
            end else begin
                if (rd_en && addr == 3'd5)
                    err <= 1'b0;
                case (state)
                    RUN: begin
                        if (data_wr || start)
                            err <= 1'b1;
                        if (cnt == 8'd1) begin
                            result <= des_result;
                            state  <= DONE;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end else begin
                            cnt <= cnt - 8'd1;
                        end
                    end
                    default: begin
                        if (data_wr) begin
                            mask[~addr[1:0]] <= 1'b1;
                            case (addr[1:0])
                                2'd0:    pt[63:32]  <= wdata;
                                2'd1:    pt[31:0]   <= wdata;
                                2'd2:    key[63:32] <= wdata;
                                default: key[31:0]  <= wdata;
                            endcase
                        end
                        if (start && &mask) begin
                            state <= RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                            cnt   <= 8'(LATENCY);
                            // Keeping the key bits lets the next block reuse the loaded key
                            mask  <= KEY_KEEP ? {2'b00, mask[1:0]} : 4'b0000;
                        end else if (start) begin
                            err <= 1'b1;
                        end else if (state == DONE && rd_en && addr == 3'd7) begin
                            state <= IDLE;
                            done  <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_des_cpu_if.sv
// tb_des_cpu_if: randomized and directed checks of des_cpu_if against a behavioural model.
module tb_des_cpu_if;
    logic        clk = 1'b0, rst = 1'b1;
    logic        wr_en = 1'b0, rd_en = 1'b0;
    logic [2:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [63:0] des_result = '0;
    logic [31:0] rdata;
    logic        rdata_valid, busy, done;
    logic [63:0] des_plaintext, des_key;

    logic        wr_b = 1'b0, rd_b = 1'b0;
    logic [2:0]  addr_b = '0;
    logic [31:0] wdata_b = '0;
    logic [31:0] rdata_b;
    logic        rv_b, busy_b, done_b;
    logic [63:0] pt_b, key_b;

    int total = 0, bad = 0;
    localparam int LAT = 16;

    des_cpu_if u_a (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata),
        .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy), .done(done),
        .des_plaintext(des_plaintext), .des_key(des_key), .des_result(des_result)
    );

    des_cpu_if #(.LATENCY(16), .KEY_KEEP(1'b0)) u_b (
        .clk(clk), .rst(rst), .wr_en(wr_b), .rd_en(rd_b), .addr(addr_b), .wdata(wdata_b),
        .rdata(rdata_b), .rdata_valid(rv_b), .busy(busy_b), .done(done_b),
        .des_plaintext(pt_b), .des_key(key_b), .des_result(des_result)
    );

    always #5 clk = ~clk;

    // Model: four stored words, which of them are loaded, run countdown, status flags
    logic [31:0] m_words[4];
    logic        have[4];
    logic [63:0] m_res;
    logic        m_err, m_done, m_run, m_rv;
    int          m_left;
    logic [31:0] m_rd;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_words[i] = '0;
            have[i] = 1'b0;
        end
        m_res = '0; m_err = 0; m_done = 0; m_run = 0; m_rv = 0; m_left = 0; m_rd = '0;
    endtask

    task automatic step(input logic w, input logic r, input logic [2:0] a, input logic [31:0] d);
        logic clr, st;
        int status;
        clr = w && a == 3'd4 && d[1];
        st  = w && a == 3'd4 && d[0] && !d[1];
        status = (have[0] ? 128 : 0) + (have[1] ? 64 : 0) + (have[2] ? 32 : 0) + (have[3] ? 16 : 0)
               + (m_err ? 4 : 0) + (m_done ? 2 : 0) + (m_run ? 1 : 0);
        m_rv = r;
        if (r)
            m_rd = a == 3'd5 ? 32'(status) : a == 3'd6 ? m_res[63:32] : a == 3'd7 ? m_res[31:0] : 32'd0;
        if (clr) begin
            m_run = 0; m_done = 0; m_err = 0;
            for (int i = 0; i < 4; i++) have[i] = 1'b0;
        end else if (m_run) begin
            if (r && a == 3'd5) m_err = 0;
            if ((w && a < 3'd4) || st) m_err = 1;
            m_left--;
            if (m_left == 0) begin
                m_run = 0; m_done = 1; m_res = des_result;
            end
        end else begin
            if (r && a == 3'd5) m_err = 0;
            if (w && a < 3'd4) begin
                m_words[a[1:0]] = d;
                have[a[1:0]] = 1'b1;
            end
            if (st) begin
                if (have[0] && have[1] && have[2] && have[3]) begin
                    m_run = 1; m_left = LAT; m_done = 0;
                    have[0] = 0; have[1] = 0;
                end else begin
                    m_err = 1;
                end
            end else if (r && a == 3'd7) begin
                m_done = 0;
            end
        end
    endtask

    task automatic op(input logic w, input logic r, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en = w; rd_en = r; addr = a; wdata = d;
        step(w, r, a, d);
        @(posedge clk);
        #1;
        wr_en = 0; rd_en = 0;
    endtask

    task automatic op_b(input logic w, input logic r, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_b = w; rd_b = r; addr_b = a; wdata_b = d;
        @(posedge clk);
        #1;
        wr_b = 0; rd_b = 0;
    endtask

    task automatic load(input logic [63:0] p, input logic [63:0] k);
        op(1, 0, 3'd0, p[63:32]);
        op(1, 0, 3'd1, p[31:0]);
        op(1, 0, 3'd2, k[63:32]);
        op(1, 0, 3'd3, k[31:0]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        model_reset();
        @(negedge clk);
        total++;
        if ({busy, done, rdata_valid, rdata, des_plaintext, des_key} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b rv=%b rdata=%h pt=%h key=%h, want all 0",
                     busy, done, rdata_valid, rdata, des_plaintext, des_key);
        end
        rst = 0;
        op(0, 1, 3'd5, 0);
        total++;
        if (rdata !== 32'h0 || rdata_valid !== 1'b1) begin
            bad++;
            $display("FAIL reset_status: got rdata=%h rv=%b, want 00000000 rv=1", rdata, rdata_valid);
        end
    endtask

    task automatic test_vector();
        int n;
        do_reset();
        load(64'h0123456789ABCDEF, 64'h133457799BBCDFF1);
        total++;
        if (des_plaintext !== 64'h0123456789ABCDEF || des_key !== 64'h133457799BBCDFF1) begin
            bad++;
            $display("FAIL vector_load: got pt=%h key=%h, want 0123456789abcdef 133457799bbcdff1",
                     des_plaintext, des_key);
        end
        des_result = 64'h85E813540F0AB405;
        op(1, 0, 3'd4, 32'h1);
        n = 0;
        while (busy && n < 100) begin
            n++;
            op(0, 0, 3'd0, 0);
        end
        total++;
        if (n !== 16 || done !== 1'b1) begin
            bad++;
            $display("FAIL vector_latency: got busy_cycles=%0d done=%b, want 16 done=1", n, done);
        end
        op(0, 1, 3'd6, 0);
        total++;
        if (rdata !== 32'h85E81354 || rdata_valid !== 1'b1) begin
            bad++;
            $display("FAIL vector_res_hi: got %h rv=%b, want 85e81354 rv=1", rdata, rdata_valid);
        end
        op(0, 1, 3'd7, 0);
        total++;
        if (rdata !== 32'h0F0AB405 || done !== 1'b0) begin
            bad++;
            $display("FAIL vector_res_lo: got %h done=%b, want 0f0ab405 done=0", rdata, done);
        end
    endtask

    task automatic test_incomplete();
        do_reset();
        op(1, 0, 3'd0, 32'h11111111);
        op(1, 0, 3'd1, 32'h22222222);
        op(1, 0, 3'd2, 32'h33333333);
        op(1, 0, 3'd4, 32'h1);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL incomplete_busy: got %b, want 0", busy);
        end
        op(0, 1, 3'd5, 0);
        total++;
        if (rdata !== 32'h000000E4) begin
            bad++;
            $display("FAIL incomplete_status1: got %h, want 000000e4", rdata);
        end
        op(0, 1, 3'd5, 0);
        total++;
        if (rdata !== 32'h000000E0) begin
            bad++;
            $display("FAIL incomplete_status2: got %h, want 000000e0", rdata);
        end
    endtask

    task automatic test_run_write();
        do_reset();
        load(64'h0123456789ABCDEF, 64'h133457799BBCDFF1);
        des_result = 64'hA5A5A5A55A5A5A5A;
        op(1, 0, 3'd4, 32'h1);
        for (int k = 1; k <= 15; k++) begin
            if (k == 3) op(1, 0, 3'd0, 32'hFFFFFFFF);
            else if (k == 5) op(0, 1, 3'd5, 0);
            else op(0, 0, 3'd0, 0);
            if (k == 5) begin
                total++;
                if (rdata !== 32'h00000035) begin
                    bad++;
                    $display("FAIL run_write_status: got %h, want 00000035", rdata);
                end
            end
        end
        total++;
        if (busy !== 1'b1 || des_plaintext !== 64'h0123456789ABCDEF) begin
            bad++;
            $display("FAIL run_write_hold: got busy=%b pt=%h, want busy=1 pt=0123456789abcdef", busy, des_plaintext);
        end
        des_result = 64'hFEEDFACECAFEBABE;
        op(0, 0, 3'd0, 0);
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL run_write_done: got done=%b busy=%b, want done=1 busy=0", done, busy);
        end
        op(0, 1, 3'd6, 0);
        total++;
        if (rdata !== 32'hFEEDFACE) begin
            bad++;
            $display("FAIL run_write_capture: got %h, want feedface", rdata);
        end
    endtask

    task automatic test_key_keep();
        op(1, 0, 3'd0, 32'hDEADBEEF);
        op(1, 0, 3'd1, 32'h01234567);
        op(1, 0, 3'd4, 32'h1);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL key_keep1_start: got busy=%b, want 1", busy);
        end
        op(1, 0, 3'd4, 32'h3);
        op(0, 1, 3'd5, 0);
        total++;
        if (busy !== 1'b0 || rdata !== 32'h0) begin
            bad++;
            $display("FAIL clear_status: got busy=%b status=%h, want busy=0 status=00000000", busy, rdata);
        end
        op_b(1, 0, 3'd0, 32'h01234567);
        op_b(1, 0, 3'd1, 32'h89ABCDEF);
        op_b(1, 0, 3'd2, 32'h13345779);
        op_b(1, 0, 3'd3, 32'h9BBCDFF1);
        op_b(1, 0, 3'd4, 32'h1);
        repeat (16) op_b(0, 0, 3'd0, 0);
        total++;
        if (done_b !== 1'b1) begin
            bad++;
            $display("FAIL key_keep0_first: got done=%b, want 1", done_b);
        end
        op_b(1, 0, 3'd0, 32'hDEADBEEF);
        op_b(1, 0, 3'd1, 32'h01234567);
        op_b(1, 0, 3'd4, 32'h1);
        op_b(0, 1, 3'd5, 0);
        total++;
        if (busy_b !== 1'b0 || rdata_b !== 32'h000000C6) begin
            bad++;
            $display("FAIL key_keep0_reject: got busy=%b status=%h, want busy=0 status=000000c6", busy_b, rdata_b);
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        load(64'h0123456789ABCDEF, 64'h133457799BBCDFF1);
        op(1, 0, 3'd4, 32'h1);
        repeat (4) op(0, 0, 3'd0, 0);
        rst = 1;
        #1;
        total++;
        if ({busy, done, rdata_valid, rdata, des_plaintext, des_key} !== '0) begin
            bad++;
            $display("FAIL midrun_reset: got busy=%b done=%b pt=%h key=%h, want all 0",
                     busy, done, des_plaintext, des_key);
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst = 0;
        for (int i = 0; i < 30; i++) begin
            op(0, 0, 3'd0, 0);
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL midrun_no_done: cycle %0d got done=%b busy=%b, want 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_same_cycle();
        do_reset();
        load(64'h0123456789ABCDEF, 64'h133457799BBCDFF1);
        op(1, 1, 3'd4, 32'h1);
        total++;
        if (rdata !== 32'h0 || rdata_valid !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL same_cycle_start: got rdata=%h rv=%b busy=%b, want 00000000 1 1", rdata, rdata_valid, busy);
        end
        op(0, 1, 3'd5, 0);
        total++;
        if (rdata !== 32'h00000031) begin
            bad++;
            $display("FAIL same_cycle_status: got %h, want 00000031", rdata);
        end
        op(1, 0, 3'd4, 32'h2);
    endtask

    task automatic test_random();
        logic w, r;
        logic [2:0] a;
        logic [31:0] d;
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            des_result = {$urandom, $urandom};
            a = 3'($urandom_range(0, 7));
            w = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 2) == 0);
            d = (a == 3'd4) ? (($urandom_range(0, 15) == 0) ? 32'h2 : 32'h1) : $urandom;
            op(w, r, a, d);
            total++;
            if (busy !== m_run || done !== m_done || rdata_valid !== m_rv || (m_rv && rdata !== m_rd) ||
                des_plaintext !== {m_words[0], m_words[1]} || des_key !== {m_words[2], m_words[3]}) begin
                bad++;
                $display("FAIL random cycle %0d (got/exp): busy=%b/%b done=%b/%b rv=%b/%b rdata=%h/%h pt=%h/%h key=%h/%h",
                         i, busy, m_run, done, m_done, rdata_valid, m_rv, rdata, m_rd,
                         des_plaintext, {m_words[0], m_words[1]}, des_key, {m_words[2], m_words[3]});
            end
        end
    endtask

    initial begin
        test_reset();
        test_vector();
        test_incomplete();
        test_run_write();
        test_key_keep();
        test_reset_mid_run();
        test_same_cycle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
